// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment receive path: active-high glyph
// patterns for the hex digit set and the capture FSM state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG7_GLYPH_0 = 7'h3F;
  localparam logic [6:0] SEG7_GLYPH_1 = 7'h06;
  localparam logic [6:0] SEG7_GLYPH_2 = 7'h5B;
  localparam logic [6:0] SEG7_GLYPH_3 = 7'h4F;
  localparam logic [6:0] SEG7_GLYPH_4 = 7'h66;
  localparam logic [6:0] SEG7_GLYPH_5 = 7'h6D;
  localparam logic [6:0] SEG7_GLYPH_6 = 7'h7D;
  localparam logic [6:0] SEG7_GLYPH_7 = 7'h07;
  localparam logic [6:0] SEG7_GLYPH_8 = 7'h7F;
  localparam logic [6:0] SEG7_GLYPH_9 = 7'h67;
  localparam logic [6:0] SEG7_GLYPH_A = 7'h77;
  localparam logic [6:0] SEG7_GLYPH_B = 7'h7C;
  localparam logic [6:0] SEG7_GLYPH_C = 7'h39;
  localparam logic [6:0] SEG7_GLYPH_D = 7'h5E;
  localparam logic [6:0] SEG7_GLYPH_E = 7'h79;
  localparam logic [6:0] SEG7_GLYPH_F = 7'h71;
  localparam logic [6:0] SEG7_BLANK   = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } seg7_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup of an active-high segment pattern to its hex nibble.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_nibble,
  output logic       o_is_glyph,
  output logic       o_is_blank
);

  // Map the pattern onto the glyph set; anything else is neither glyph nor blank.
  always_comb begin
    o_nibble   = 4'h0;
    o_is_glyph = 1'b1;
    o_is_blank = 1'b0;
    case (i_pat)
      SEG7_GLYPH_0: o_nibble = 4'h0;
      SEG7_GLYPH_1: o_nibble = 4'h1;
      SEG7_GLYPH_2: o_nibble = 4'h2;
      SEG7_GLYPH_3: o_nibble = 4'h3;
      SEG7_GLYPH_4: o_nibble = 4'h4;
      SEG7_GLYPH_5: o_nibble = 4'h5;
      SEG7_GLYPH_6: o_nibble = 4'h6;
      SEG7_GLYPH_7: o_nibble = 4'h7;
      SEG7_GLYPH_8: o_nibble = 4'h8;
      SEG7_GLYPH_9: o_nibble = 4'h9;
      SEG7_GLYPH_A: o_nibble = 4'hA;
      SEG7_GLYPH_B: o_nibble = 4'hB;
      SEG7_GLYPH_C: o_nibble = 4'hC;
      SEG7_GLYPH_D: o_nibble = 4'hD;
      SEG7_GLYPH_E: o_nibble = 4'hE;
      SEG7_GLYPH_F: o_nibble = 4'hF;
      SEG7_BLANK: begin
        o_is_glyph = 1'b0;
        o_is_blank = 1'b1;
      end
      default: o_is_glyph = 1'b0;
    endcase
  end

endmodule

// File: rtl/sync_cell.sv
// Generic multi-bit flop-chain synchronizer with a configurable reset value.
module sync_cell #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q [STAGES];

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) r_q[s] <= RST_VAL;
    end else begin
      r_q[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_q[s] <= r_q[s-1];
    end
  end

  assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/seg7_rx_decoder.sv
// Samples a multiplexed active-low seven-segment bus, waits for each digit's
// pattern to be stable, and captures the recovered hex nibble per digit.
module seg7_rx_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err,
  output logic [6:0]              err_pattern,
  output logic [2:0]              err_digit
);

  localparam int BUS_W = 7 + NUM_DIGITS;

  function automatic logic [2:0] f_onehot_idx(input logic [NUM_DIGITS-1:0] v);
    f_onehot_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) f_onehot_idx = 3'(i);
    end
  endfunction

  logic [1:0]              r_rst_sync;
  logic                    w_rst_n;
  logic [BUS_W-1:0]        w_bus_s;
  logic [6:0]              w_pat;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic                    w_onehot;
  logic                    w_changed;
  logic [2:0]              w_idx;
  logic [NUM_DIGITS-1:0]   w_seen_next;
  logic [3:0]              w_nibble;
  logic                    w_is_glyph;
  logic                    w_is_blank;

  seg7_state_t             r_state;
  logic [7:0]              r_count;
  logic [BUS_W-1:0]        r_prev;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic                    r_frame_done;
  logic                    r_err;
  logic [6:0]              r_err_pattern;
  logic [2:0]              r_err_digit;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Both segment and select lines idle high, so the chain resets to all ones.
  sync_cell #(
    .WIDTH   (BUS_W),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ({BUS_W{1'b1}})
  ) u_sync (
    .clk   (clk),
    .rst_n (w_rst_n),
    .i_d   ({seg_n, dig_sel_n}),
    .o_q   (w_bus_s)
  );

  assign w_pat       = ~w_bus_s[BUS_W-1:NUM_DIGITS];
  assign w_sel       = ~w_bus_s[NUM_DIGITS-1:0];
  assign w_onehot    = (w_sel != '0) && ((w_sel & (w_sel - 1'b1)) == '0);
  assign w_changed   = ({w_pat, w_sel} != r_prev);
  assign w_idx       = f_onehot_idx(w_sel);
  assign w_seen_next = r_seen | w_sel;

  seg7_pattern_decode u_decode (
    .i_pat      (w_pat),
    .o_nibble   (w_nibble),
    .o_is_glyph (w_is_glyph),
    .o_is_blank (w_is_blank)
  );

  // Stability FSM plus capture of the selected digit once the bus has settled.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= IDLE;
      r_count       <= 8'd0;
      r_prev        <= '0;
      r_seen        <= '0;
      r_digits      <= '0;
      r_valid       <= '0;
      r_frame_done  <= 1'b0;
      r_err         <= 1'b0;
      r_err_pattern <= 7'h00;
      r_err_digit   <= 3'd0;
    end else begin
      r_prev       <= {w_pat, w_sel};
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_onehot) begin
            r_state <= SETTLE;
            r_count <= 8'd1;
          end
        end
        SETTLE: begin
          if (w_changed) begin
            r_count <= 8'd1;
            r_state <= w_onehot ? SETTLE : IDLE;
          end else if (r_count == 8'(STABLE_CYCLES - 1)) begin
            r_count <= 8'(STABLE_CYCLES);
            r_state <= CAPTURED;
            if (w_is_glyph || w_is_blank) begin
              if (w_is_glyph) begin
                r_digits[4*int'(w_idx) +: 4] <= w_nibble;
                r_valid[w_idx]               <= 1'b1;
              end else begin
                r_valid[w_idx] <= 1'b0;
              end
              if (&w_seen_next) begin
                r_frame_done <= 1'b1;
                r_seen       <= '0;
              end else begin
                r_seen <= w_seen_next;
              end
            end else begin
              r_err         <= 1'b1;
              r_err_pattern <= w_pat;
              r_err_digit   <= w_idx;
            end
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        CAPTURED: begin
          if (w_changed) begin
            r_count <= 8'd1;
            r_state <= w_onehot ? SETTLE : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign digits_o    = r_digits;
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign err         = r_err;
  assign err_pattern = r_err_pattern;
  assign err_digit   = r_err_digit;

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Scoreboard bench for seg7_rx_decoder: each stimulus step predicts its capture
// (edge, resulting outputs) and a negedge monitor checks the DUT every cycle.
module tb_seg7_rx_decoder;

  localparam int ND      = 4;
  localparam int STABLE  = 4;
  localparam int SYNC    = 2;
  localparam int RST_LAT = 2;
  localparam int LAT     = SYNC + STABLE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    seg_n = 7'h7F;
  logic [ND-1:0] dig_sel_n = '1;
  logic [15:0]   digits_o;
  logic [ND-1:0] digit_valid;
  logic          frame_done;
  logic          err;
  logic [6:0]    err_pattern;
  logic [2:0]    err_digit;

  seg7_rx_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (STABLE),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_sel_n   (dig_sel_n),
    .digits_o    (digits_o),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err         (err),
    .err_pattern (err_pattern),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          cyc;
    logic [15:0] dig;
    logic [3:0]  vld;
    logic        fd;
    logic        er;
    logic [6:0]  ep;
    logic [2:0]  ed;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int nib_of(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (GLYPH[i] == p) return i;
    return -1;
  endfunction

  // Reference model state
  logic [15:0]   m_dig  = '0;
  logic [ND-1:0] m_vld  = '0;
  logic [ND-1:0] m_seen = '0;
  logic [6:0]    m_ep   = '0;
  logic [2:0]    m_ed   = '0;
  logic [ND-1:0] prev_sel_n = '1;
  logic [6:0]    prev_seg_n = 7'h7F;

  // Drive one bus value for n cycles; predict its capture if it will happen.
  task automatic drive(input logic [ND-1:0] sel_n, input logic [6:0] sg_n,
                       input int n, input int extra = 0);
    exp_t e;
    logic [6:0]    p;
    logic [ND-1:0] s;
    int idx;
    int nib;
    dig_sel_n = sel_n;
    seg_n     = sg_n;
    p = ~sg_n;
    s = ~sel_n;
    if (({sel_n, sg_n} != {prev_sel_n, prev_seg_n}) && ($countones(s) == 1) && (n >= STABLE)) begin
      idx = 0;
      for (int i = 0; i < ND; i++) if (s[i]) idx = i;
      nib = nib_of(p);
      e.cyc = edge_cnt + LAT + extra;
      e.fd  = 1'b0;
      e.er  = 1'b0;
      if (nib >= 0) begin
        m_dig[4*idx +: 4] = 4'(nib);
        m_vld[idx]  = 1'b1;
        m_seen[idx] = 1'b1;
      end else if (p == 7'h00) begin
        m_vld[idx]  = 1'b0;
        m_seen[idx] = 1'b1;
      end else begin
        e.er = 1'b1;
        m_ep = p;
        m_ed = 3'(idx);
      end
      if (m_seen == '1) begin
        e.fd   = 1'b1;
        m_seen = '0;
      end
      e.dig = m_dig;
      e.vld = m_vld;
      e.ep  = m_ep;
      e.ed  = m_ed;
      sb.push_back(e);
    end
    prev_sel_n = sel_n;
    prev_seg_n = sg_n;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare all outputs against the scoreboard state every cycle.
  bit          mon_en = 1'b0;
  exp_t        me;
  logic [15:0] c_dig = '0;
  logic [3:0]  c_vld = '0;
  logic [6:0]  c_ep  = '0;
  logic [2:0]  c_ed  = '0;
  logic        c_fd;
  logic        c_er;

  always @(negedge clk) begin
    if (!mon_en) begin
      c_dig = '0;
      c_vld = '0;
      c_ep  = '0;
      c_ed  = '0;
    end else begin
      c_fd = 1'b0;
      c_er = 1'b0;
      if (sb.size() > 0 && sb[0].cyc == edge_cnt) begin
        me    = sb.pop_front();
        c_dig = me.dig;
        c_vld = me.vld;
        c_ep  = me.ep;
        c_ed  = me.ed;
        c_fd  = me.fd;
        c_er  = me.er;
      end
      check("digits_o",    32'(digits_o),    32'(c_dig));
      check("digit_valid", 32'(digit_valid), 32'(c_vld));
      check("frame_done",  32'(frame_done),  32'(c_fd));
      check("err",         32'(err),         32'(c_er));
      check("err_pattern", 32'(err_pattern), 32'(c_ep));
      check("err_digit",   32'(err_digit),   32'(c_ed));
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single digit: '2' on digit 0
    drive(4'b1110, ~7'h5B, 10);

    // Full scan 1, A, d, F with long holds
    drive(4'b1110, ~7'h06, 10);
    drive(4'b1101, ~7'h77, 10);
    drive(4'b1011, ~7'h5E, 10);
    drive(4'b0111, ~7'h71, 10);

    // Second scan with holds exactly at the stability threshold
    drive(4'b1110, ~7'h4F, STABLE);
    drive(4'b1101, ~7'h6D, STABLE);
    drive(4'b1011, ~7'h07, STABLE);
    drive(4'b0111, ~7'h67, STABLE);

    // Short glitch on digit 1 must not capture
    drive(4'b1101, ~7'h6D, 10);
    drive(4'b1101, ~7'h06, STABLE - 1);
    drive(4'b1101, ~7'h6D, 10);

    // Illegal pattern on digit 2
    drive(4'b1011, ~7'h49, 8);

    // Digit 0: '8' then blank, then overlapping selects
    drive(4'b1110, ~7'h7F, 10);
    drive(4'b1110, 7'h7F, 10);
    drive(4'b1100, ~7'h06, 10);

    // Reset in the middle of digit 3's settle window
    drive(4'b0111, ~7'h07, 3);
    #2;
    mon_en = 1'b0;
    sb.delete();
    rst_n = 1'b0;
    #1;
    check("rst digits_o",    32'(digits_o),    32'h0);
    check("rst digit_valid", 32'(digit_valid), 32'h0);
    check("rst frame_done",  32'(frame_done),  32'h0);
    check("rst err",         32'(err),         32'h0);
    check("rst err_pattern", 32'(err_pattern), 32'h0);
    check("rst err_digit",   32'(err_digit),   32'h0);
    m_dig  = '0;
    m_vld  = '0;
    m_seen = '0;
    m_ep   = '0;
    m_ed   = '0;
    prev_sel_n = '1;
    prev_seg_n = 7'h7F;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drive(4'b0111, ~7'h07, 12, RST_LAT);

    // Return bus to idle
    drive(4'b1111, 7'h7F, 10);

    check("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_rx_decoder.md
Name: seg7_rx_decoder

Overview:
- Receive-side counterpart of the board's nibble-to-seven-segment driver.
- Samples an external, time-multiplexed, active-low seven-segment bus (segment lines plus active-low digit selects) and recovers the hex nibble shown on each digit.
- Publishes per-digit nibble registers, per-digit valid flags, a frame-complete pulse and an error report for patterns that are not in the hex glyph set.
- Used to read front panels and to loop the display output back into the CPU test harness.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8)
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before capture (2..255)
- SYNC_STAGES, 2, flip-flop stages on every bus input (2..3)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_n  in  7  active-low segments; bit0=a .. bit6=g
- dig_sel_n  in  NUM_DIGITS  active-low digit selects; exactly one low selects that digit
- digits_o  out  4*NUM_DIGITS  recovered nibbles; digit i occupies bits [4i+3:4i]
- digit_valid  out  NUM_DIGITS  digit i holds a decoded glyph
- frame_done  out  1  one-cycle pulse when every digit has been captured since the previous pulse
- err  out  1  one-cycle pulse on capture of an illegal pattern
- err_pattern  out  7  active-high segment pattern of the last illegal capture
- err_digit  out  3  digit index of the last illegal capture

Behaviour:
- Reset (async assert, sync deassert internally): digits_o=0, digit_valid=0, frame_done=0, err=0, err_pattern=0, err_digit=0, FSM=IDLE, stability count=0, seen mask=0, synchronizers=all ones (bus idle).
- Every bit of seg_n and dig_sel_n passes through SYNC_STAGES flops. All later logic uses the synchronized values (pat = ~seg_s, sel = ~dig_sel_s).
- Legal glyphs (pat, active-high, hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=67 A=77 b=7C C=39 d=5E E=79 F=71. Blank is 00.
- FSM IDLE:
  - stay while sel is not exactly one-hot (zero or multiple selects);
  - on one-hot -> SETTLE, count=1.
- FSM SETTLE:
  - if {pat,sel} differs from the previous cycle: count=1; stay in SETTLE if sel is one-hot, else -> IDLE;
  - otherwise count++. When count reaches STABLE_CYCLES, capture on that edge -> CAPTURED.
- FSM CAPTURED:
  - hold while {pat,sel} is unchanged; only one capture per stable window;
  - on change: -> SETTLE (count=1) if one-hot, else -> IDLE.
- Capture into digit i (i = index of the selected digit):
  - legal glyph: digits_o[i]=nibble, digit_valid[i]=1, seen[i]=1;
  - blank: digit_valid[i]=0, digits_o[i] unchanged, seen[i]=1;
  - illegal: err=1 for one cycle, err_pattern=pat, err_digit=i; digits_o[i], digit_valid[i] and seen unchanged.
- Latency: for a bus value held constant, outputs update on the edge numbered SYNC_STAGES+STABLE_CYCLES, counting the first edge that samples the new value as 1. Default is 6.
- frame_done: when a capture makes the seen mask all ones, pulse frame_done on the same edge as that capture and clear the mask to 0.
- A glitch shorter than STABLE_CYCLES synchronized cycles never captures.
- A change exactly on the capture edge counts as a change: no capture, count=1.
- Reset mid-window discards the count and the seen mask. Outputs return to their reset values immediately.

Decomposition:
- Package seg7_pkg:
  - localparams for the 16 glyph patterns (active-high) and SEG7_BLANK=7'h00;
  - FSM state typedef {IDLE, SETTLE, CAPTURED}.
- Sub-module seg7_pattern_decode: purely combinational; pat[6:0] -> nibble[3:0], is_glyph, is_blank.
- The synchronizer is a generic instance of the team's standard sync cell.

Test Plan:
- Reset, then drive dig_sel_n=4'b1110 and seg_n=~7'h5B, held -> digits_o[3:0]=2 and digit_valid=0001 on edge 6; err=0.
- Scan digits 0..3 with glyphs 1, A, d, F, each held 10 cycles -> digits_o=16'hFDA1, digit_valid=1111, a single frame_done pulse on digit 3's capture edge, and a second pulse after a second full scan.
- Digit 1 holds seg_n=~7'h6D, then one 3-cycle burst of ~7'h06 -> digits_o[7:4] stays 5, no err.
- Digit 2 driven with illegal ~7'h49 for 8 cycles -> one err pulse, err_pattern=7'h49, err_digit=2, digit_valid[2] unchanged.
- Digit 0 valid with 8, then blank (seg_n=7'h7F) -> digit_valid[0]=0 and digits_o[3:0] still 8. Overlapping selects (dig_sel_n=4'b1100) -> no capture.
- Assert rst_n low during SETTLE of digit 3 -> all outputs zero immediately. After release, a full 6-cycle window is required before capture.
